// File: rtl/wm_pkg.sv
// Shared stage codes, panel state encoding and registered-output bundle for the
// washing-machine front panel.
package wm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_WASH  = 3'd2,
      ST_RINSE = 3'd3,
      ST_SPIN  = 3'd4,
      ST_DONE  = 3'd5
   } stage_e;

   typedef enum logic [2:0] {
      P_IDLE,
      P_RUN,
      P_PAUSED,
      P_FINISH,
      P_FAULT
   } panel_state_e;

   typedef struct packed {
      logic start;
      logic pause;
      logic machine_rst;
      logic buzzer;
      logic door_lock;
      logic fault;
   } panel_out_t;

   localparam logic [5:0] LED_IDLE = 6'b000001;

   // Codes 6/7 map to all-zero; callers treat that as "no valid stage".
   function automatic logic [5:0] stage_onehot(input logic [2:0] code);
      logic [5:0] v;
      v = '0;
      if (code <= ST_DONE) v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/wm_debounce.sv
// Button debouncer: filtered level follows the raw input only after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles; o_press pulses one cycle on an accepted rise.
module wm_debounce
   import wm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_press;
   logic          w_differ;
   logic          w_accept;

   assign w_differ = (i_raw != r_level);
   assign w_accept = w_differ && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_press <= w_accept && i_raw;
         if (w_accept) begin
            r_level <= i_raw;
            r_cnt   <= '0;
         end else if (w_differ) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/wm_panel.sv
// Washing-machine front panel: debounced buttons, run/pause/finish sequencing and stage display.
// Stall watchdog and the fault state are built only when WM_PANEL_WATCHDOG_EN is defined.
module wm_panel
   import wm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BUZZ_CYCLES     = 8,
   parameter int STALL_LIMIT     = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic [2:0] stage,
   input  logic       done,
   output logic       start,
   output logic       pause,
   output logic       machine_rst,
   output logic [5:0] stage_led,
   output logic       buzzer,
   output logic       door_lock,
   output logic       fault
);

   localparam int BW = $clog2(BUZZ_CYCLES + 1);
   localparam logic [BW-1:0] BUZZ_END = BW'(BUZZ_CYCLES);

   panel_state_e  r_state;
   panel_state_e  w_nxt_state;
   logic [BW-1:0] r_buzz_cnt;
   logic [BW-1:0] w_nxt_buzz_cnt;
   logic          w_fault_clear;
   panel_out_t    r_out;
   panel_out_t    w_nxt_out;
   logic [5:0]    r_led;
   logic [2:0]    r_last_stage;
   logic          w_start_press;
   logic          w_pause_press;
   logic          w_stall;

   wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (btn_start),
      .o_press (w_start_press)
   );

   wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (btn_pause),
      .o_press (w_pause_press)
   );

`ifdef WM_PANEL_WATCHDOG_EN
   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

   logic [SW-1:0] r_stall_cnt;
   logic [2:0]    r_stage_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt  <= '0;
         r_stage_prev <= ST_IDLE;
      end else begin
         r_stage_prev <= stage;
         if ((stage != r_stage_prev) || (w_nxt_state == P_RUN && r_state != P_RUN)) begin
            r_stall_cnt <= '0;
         end else if (r_state == P_RUN && r_stall_cnt != STALL_MAX) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   // A machine parked in "done" is waiting on us, not stalled.
   assign w_stall = (r_stall_cnt == STALL_MAX) && (stage != ST_DONE);
`else
   assign w_stall = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= P_IDLE;
         r_buzz_cnt <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_buzz_cnt <= w_nxt_buzz_cnt;
      end
   end

   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_buzz_cnt = '0;
      w_fault_clear  = 1'b0;
      w_nxt_out      = '0;

      case (r_state)
         P_IDLE: begin
            if (w_start_press) w_nxt_state = P_RUN;
         end
         P_RUN: begin
            if (done)               w_nxt_state = P_FINISH;
            else if (w_pause_press) w_nxt_state = P_PAUSED;
            else if (w_stall)       w_nxt_state = P_FAULT;
         end
         P_PAUSED: begin
            if (w_pause_press) w_nxt_state = P_RUN;
         end
         P_FINISH: begin
            // Counter runs 0..BUZZ_END-1 buzzing, BUZZ_END is the reset-pulse cycle.
            if (r_buzz_cnt == BUZZ_END) w_nxt_state = P_IDLE;
            else                        w_nxt_buzz_cnt = r_buzz_cnt + 1'b1;
         end
         P_FAULT: begin
            if (w_start_press) begin
               w_nxt_state   = P_IDLE;
               w_fault_clear = 1'b1;
            end
         end
         default: w_nxt_state = P_IDLE;
      endcase

      case (w_nxt_state)
         P_IDLE: begin
            w_nxt_out.machine_rst = w_fault_clear;
         end
         P_RUN: begin
            w_nxt_out.start     = 1'b1;
            w_nxt_out.door_lock = 1'b1;
         end
         P_PAUSED: begin
            w_nxt_out.start = 1'b1;
            w_nxt_out.pause = 1'b1;
         end
         P_FINISH: begin
            if (w_nxt_buzz_cnt == BUZZ_END) begin
               w_nxt_out.machine_rst = 1'b1;
            end else begin
               w_nxt_out.start  = 1'b1;
               w_nxt_out.buzzer = 1'b1;
            end
         end
         P_FAULT: begin
            w_nxt_out.pause  = 1'b1;
            w_nxt_out.buzzer = 1'b1;
`ifdef WM_PANEL_WATCHDOG_EN
            w_nxt_out.fault  = 1'b1;
`endif
         end
         default: w_nxt_out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_out <= '0;
      else        r_out <= w_nxt_out;
   end

   // While paused the machine may report idle; keep showing where the cycle stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led        <= LED_IDLE;
         r_last_stage <= ST_IDLE;
      end else begin
         if (r_state == P_PAUSED)  r_led <= stage_onehot(r_last_stage);
         else if (stage <= ST_DONE) r_led <= stage_onehot(stage);
         if (stage != ST_IDLE && stage <= ST_DONE) r_last_stage <= stage;
      end
   end

   assign start       = r_out.start;
   assign pause       = r_out.pause;
   assign machine_rst = r_out.machine_rst;
   assign buzzer      = r_out.buzzer;
   assign door_lock   = r_out.door_lock;
   assign fault       = r_out.fault;
   assign stage_led   = r_led;

endmodule

// File: tb/tb_wm_panel.sv
// Scoreboard bench for wm_panel: directed scenarios then random stimulus, checked against
// a behavioural panel model; honours WM_PANEL_WATCHDOG_EN the same way as the design.
module tb_wm_panel;

   localparam int DEB   = 4;
   localparam int BUZZ  = 8;
   localparam int LIMIT = 64;
`ifdef WM_PANEL_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_start, btn_pause, done;
   logic [2:0] stage;
   logic       start, pause, machine_rst, buzzer, door_lock, fault;
   logic [5:0] stage_led;

   wm_panel #(.DEBOUNCE_CYCLES(DEB), .BUZZ_CYCLES(BUZZ), .STALL_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_start   (btn_start),
      .btn_pause   (btn_pause),
      .stage       (stage),
      .done        (done),
      .start       (start),
      .pause       (pause),
      .machine_rst (machine_rst),
      .stage_led   (stage_led),
      .buzzer      (buzzer),
      .door_lock   (door_lock),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       start, pause, mrst;
      logic [5:0] led;
      logic       buzz, lock, fault;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   running = 1'b1;

   // Behavioural model of the panel as seen from its pins.
   typedef enum {M_IDLE, M_RUN, M_PAUSED, M_FINISH, M_FAULT} mstate_e;
   mstate_e    m_st;
   int         m_lvl[2], m_run[2];
   bit         m_press[2];
   int         m_stall, m_prev_stage, m_fin, m_last;
   logic [5:0] m_led;
   bit         m_mrst;

   task automatic model_reset();
      m_st = M_IDLE;
      for (int i = 0; i < 2; i++) begin
         m_lvl[i] = 0; m_run[i] = 0; m_press[i] = 1'b0;
      end
      m_stall = 0; m_prev_stage = 0; m_fin = 0; m_last = 0;
      m_led = 6'b000001; m_mrst = 1'b0;
   endtask

   task automatic model_step(input logic bs, input logic bp, input logic [2:0] stg, input logic dn);
      bit      ps, pp, stall;
      int      raw[2];
      mstate_e old;
      ps = m_press[0];
      pp = m_press[1];
      raw[0] = int'(bs);
      raw[1] = int'(bp);
      for (int i = 0; i < 2; i++) begin
         m_press[i] = 1'b0;
         if (raw[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_lvl[i] = raw[i];
               m_run[i] = 0;
               m_press[i] = (raw[i] == 1);
            end
         end else begin
            m_run[i] = 0;
         end
      end
      stall = WD && (m_stall == LIMIT) && (int'(stg) != 5);
      old = m_st;
      m_mrst = 1'b0;
      case (old)
         M_IDLE:   if (ps) m_st = M_RUN;
         M_RUN: begin
            if (dn) begin m_st = M_FINISH; m_fin = 0; end
            else if (pp) m_st = M_PAUSED;
            else if (stall) m_st = M_FAULT;
         end
         M_PAUSED: if (pp) m_st = M_RUN;
         M_FINISH: begin
            if (m_fin == BUZZ) m_st = M_IDLE;
            else m_fin++;
         end
         M_FAULT:  if (ps) begin m_st = M_IDLE; m_mrst = 1'b1; end
         default:  m_st = M_IDLE;
      endcase
      if (int'(stg) != m_prev_stage || (m_st == M_RUN && old != M_RUN)) m_stall = 0;
      else if (old == M_RUN && m_stall < LIMIT) m_stall++;
      m_prev_stage = int'(stg);
      if (old == M_PAUSED) m_led = 6'(1 << m_last);
      else if (int'(stg) <= 5) m_led = 6'(1 << int'(stg));
      if (int'(stg) >= 1 && int'(stg) <= 5) m_last = int'(stg);
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e = '0;
      e.led = m_led;
      case (m_st)
         M_IDLE:   e.mrst = m_mrst;
         M_RUN:    begin e.start = 1'b1; e.lock = 1'b1; end
         M_PAUSED: begin e.start = 1'b1; e.pause = 1'b1; end
         M_FINISH: begin
            if (m_fin < BUZZ) begin e.start = 1'b1; e.buzz = 1'b1; end
            else e.mrst = 1'b1;
         end
         M_FAULT:  begin e.pause = 1'b1; e.fault = 1'b1; e.buzz = 1'b1; end
         default:  e = '0;
      endcase
      return e;
   endfunction

   function automatic exp_t dut_out();
      exp_t a;
      a = '{start, pause, machine_rst, stage_led, buzzer, door_lock, fault};
      return a;
   endfunction

   // Monitor: one registered output vector per rising edge.
   always @(posedge clk) begin
      exp_t e, a;
      #2;
      if (exp_q.size() == 0) begin
         if (running) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard_empty @%0t: output seen with no expected entry", $time);
         end
      end else begin
         e = exp_q.pop_front();
         a = dut_out();
         n_vec++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL outputs @%0t: actual %b required %b (start pause mrst led[5:0] buzz lock fault)",
                     $time, a, e);
         end
      end
   end

   logic       s_rst, s_bs, s_bp, s_dn;
   logic [2:0] s_stg;

   task automatic cyc();
      logic was_rst;
      @(negedge clk);
      was_rst = rst_n;
      rst_n = s_rst; btn_start = s_bs; btn_pause = s_bp; stage = s_stg; done = s_dn;
      if (was_rst && !s_rst) begin
         #1;
         n_vec++;
         if (dut_out() !== exp_t'({3'b000, 6'b000001, 3'b000})) begin
            n_bad++;
            $display("FAIL reset_now @%0t: actual %b required %b", $time, dut_out(),
                     exp_t'({3'b000, 6'b000001, 3'b000}));
         end
      end
      if (!s_rst) model_reset();
      else model_step(s_bs, s_bp, s_stg, s_dn);
      exp_q.push_back(model_out());
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic press_start(input int hold);
      s_bs = 1'b1; tick(hold); s_bs = 1'b0; tick(2);
   endtask

   task automatic press_pause(input int hold);
      s_bp = 1'b1; tick(hold); s_bp = 1'b0; tick(2);
   endtask

   initial begin
      int hs, hp;
      rst_n = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; stage = 3'd0; done = 1'b0;
      s_rst = 1'b0; s_bs = 1'b0; s_bp = 1'b0; s_stg = 3'd0; s_dn = 1'b0;
      model_reset();
      exp_q.push_back(model_out());
      tick(3);
      s_rst = 1'b1; tick(2);

      // Short glitch rejected, full-length press accepted.
      s_bs = 1'b1; tick(3); s_bs = 1'b0; tick(4);
      press_start(4);
      s_stg = 3'd1; tick(3); s_stg = 3'd2; tick(3);

      // Pause with stage falling to idle, then resume.
      press_pause(4);
      s_stg = 3'd0; tick(4);
      s_stg = 3'd7; tick(2);
      press_pause(5);
      s_stg = 3'd2; tick(2);
      press_start(4);

      // Completion: buzzer phase, reset pulse, back to idle.
      s_dn = 1'b1; tick(1); s_dn = 1'b0; tick(12);

      // Stage held long enough to stall, then start clears the fault.
      press_start(4);
      s_stg = 3'd3; tick(70);
      press_start(4);
      tick(2);
      s_dn = 1'b1; tick(1); s_dn = 1'b0; tick(12);

      // done coincident with an accepted pause press.
      press_start(4);
      s_stg = 3'd4;
      s_bp = 1'b1; tick(4);
      s_dn = 1'b1; s_bp = 1'b0; tick(1); s_dn = 1'b0; tick(12);

      // Reset during the buzzer phase.
      press_start(4);
      s_dn = 1'b1; tick(1); s_dn = 1'b0; tick(3);
      s_rst = 1'b0; tick(2); s_rst = 1'b1; tick(12);

      hs = 0; hp = 0;
      for (int k = 0; k < 3000; k++) begin
         if (hs == 0) begin s_bs = 1'($urandom_range(0, 1)); hs = int'($urandom_range(1, 7)); end
         if (hp == 0) begin s_bp = 1'($urandom_range(0, 1)); hp = int'($urandom_range(1, 7)); end
         hs--; hp--;
         if ($urandom_range(0, 9) == 0) s_stg = 3'($urandom_range(0, 7));
         s_dn  = ($urandom_range(0, 29) == 0);
         s_rst = ($urandom_range(0, 599) != 0);
         tick(1);
      end

      running = 1'b0;
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_vec++; n_bad++;
         $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/wm_panel.md
WM_PANEL -- requirements
Module: wm_panel

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, giving consecutive stable cycles for a button level to be accepted.
REQ-002 The module SHALL have parameter BUZZ_CYCLES, default 8, giving the buzzer on-time after a completed cycle.
REQ-003 The module SHALL have parameter STALL_LIMIT, default 64, giving the cycles without a stage change that count as a stall.
REQ-004 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port btn_start, input, 1 bit: raw front-panel start button, active high.
REQ-007 Port btn_pause, input, 1 bit: raw front-panel pause button, active high.
REQ-008 Port stage, input, 3 bits: machine stage code (idle 0, fill 1, wash 2, rinse 3, spin 4, done 5).
REQ-009 Port done, input, 1 bit: machine cycle-complete flag.
REQ-010 Port start, output, 1 bit: run-enable level to the machine.
REQ-011 Port pause, output, 1 bit: pause level to the machine.
REQ-012 Port machine_rst, output, 1 bit: one-cycle active-high reset pulse to the machine.
REQ-013 Port stage_led, output, 6 bits: one-hot displayed stage, bit index = stage code.
REQ-014 Port buzzer, output, 1 bit: buzzer drive.
REQ-015 Port door_lock, output, 1 bit: door lock solenoid, 1 = locked.
REQ-016 Port fault, output, 1 bit: stall fault indicator.

Function
REQ-017 Each button SHALL pass a debouncer: the filtered level changes only after the raw input differs from it for DEBOUNCE_CYCLES consecutive cycles; a press is a one-cycle event on the filtered rising edge.
REQ-018 Panel FSM states: P_IDLE, P_RUN, P_PAUSED, P_FINISH, P_FAULT; all outputs registered.
REQ-019 P_IDLE: start=0, pause=0, door_lock=0; start press -> P_RUN.
REQ-020 P_RUN: start=1, pause=0, door_lock=1; done=1 -> P_FINISH; else pause press -> P_PAUSED; else stall -> P_FAULT; start presses ignored.
REQ-021 P_PAUSED: start=1, pause=1, door_lock=0; pause press -> P_RUN; start presses ignored; done ignored.
REQ-022 P_FINISH: start=1, buzzer=1 for exactly BUZZ_CYCLES cycles, then machine_rst=1 for one cycle with start=0 and buzzer=0, then P_IDLE; button presses ignored.
REQ-023 P_FAULT: start=0, pause=1, fault=1, buzzer=1, door_lock=0; start press -> machine_rst one-cycle pulse and P_IDLE with fault cleared.
REQ-024 Priority in P_RUN on the same cycle: done > pause press > stall.
REQ-025 stage_led SHALL show stage when stage is 0..5 and the panel is not in P_PAUSED; in P_PAUSED it SHALL hold the last non-idle stage; codes 6/7 SHALL hold the previous display.
REQ-026 Stall counter: clears on any stage change and on entry to P_RUN, increments only in P_RUN, saturates at STALL_LIMIT; stall is asserted when it equals STALL_LIMIT and stage != 5.

Reset
REQ-027 While rst_n=0: P_IDLE, start=0, pause=0, machine_rst=0, buzzer=0, door_lock=0, fault=0, stage_led=6'b000001, counters 0, debouncer filtered levels 0.
REQ-028 Reset asserted mid-cycle SHALL abandon the cycle immediately; no machine_rst pulse is generated.

Configuration
REQ-029 Macro WM_PANEL_WATCHDOG_EN defined: stall counter and P_FAULT present per REQ-023/026.
REQ-030 Macro WM_PANEL_WATCHDOG_EN undefined: no stall counter, P_FAULT unreachable, fault tied 0; all other behaviour identical.

Structure
REQ-031 Package wm_pkg SHALL hold the stage codes (idle..donew) and the panel state enum.
REQ-032 Sub-module wm_debounce (parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification
REQ-033 btn_start high 3 cycles then low -> no press, stays P_IDLE; high 4 cycles -> start=1 on the following cycle, door_lock=1.
REQ-034 In P_RUN with stage=2, pause press -> pause=1, door_lock=0, stage drops to 0 but stage_led stays 6'b000100; second press -> pause=0.
REQ-035 In P_RUN, done=1 -> buzzer high exactly 8 cycles, then machine_rst high 1 cycle with start=0, then P_IDLE.
REQ-036 Stage held at 3 for 64 cycles in P_RUN -> fault=1, pause=1, start=0; start press -> machine_rst pulse, fault=0; watchdog-disabled build -> no fault.
REQ-037 done=1 and pause press on the same cycle in P_RUN -> P_FINISH, pause stays 0.
REQ-038 rst_n low during P_FINISH buzzer phase -> all outputs to reset values immediately, no machine_rst pulse.
